// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, no-op encodings and per-stage widths.
// Used by pipe_stage_reg (build option PIPE_STAGE_SKID_EN) and by the stage wrappers of the core.
package pipe_pkg;

    localparam int GPR_W    = 5;
    localparam int ALU_OP_W = 4;
    localparam int PCSRC_W  = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_NOP = 4'h0,
        ALU_ADD = 4'h1,
        ALU_SUB = 4'h2,
        ALU_AND = 4'h3,
        ALU_OR  = 4'h4,
        ALU_XOR = 4'h5,
        ALU_SLT = 4'h6,
        ALU_SLL = 4'h7,
        ALU_SRL = 4'h8
    } alu_op_e;

    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_PLUS4  = 2'd0,
        PCSRC_BRANCH = 2'd1,
        PCSRC_JAL    = 2'd2,
        PCSRC_JALR   = 2'd3
    } pc_src_e;

    localparam logic [GPR_W-1:0] GPR_XP   = '0;
    localparam logic             DM_R_OFF = 1'b0;
    localparam logic             DM_W_OFF = 1'b0;

    // MSB-first packing of the 16-bit control bundle.
    typedef struct packed {
        logic [1:0]       rsvd;
        pc_src_e          pc_src;
        logic             dm_w;
        logic             dm_r;
        alu_op_e          alu_op;
        logic             m2r;
        logic [GPR_W-1:0] wsel;
    } ctrl_t;

    localparam int CTRL_WSEL_LSB   = 0;
    localparam int CTRL_M2R_LSB    = 5;
    localparam int CTRL_ALU_OP_LSB = 6;
    localparam int CTRL_DM_R_LSB   = 10;
    localparam int CTRL_DM_W_LSB   = 11;
    localparam int CTRL_PCSRC_LSB  = 12;

    localparam int PIPE_CTRL_W   = $bits(ctrl_t);
    localparam int PIPE_DATA_W   = 64;
    localparam int PIPE_CNT_W    = 16;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_DATA_W  = 64;
    localparam int EX_MEM_DATA_W = 64;
    localparam int MEM_WB_DATA_W = 64;

    localparam ctrl_t CTRL_BUBBLE_DEFAULT = '{
        rsvd:   2'b00,
        pc_src: PCSRC_PLUS4,
        dm_w:   DM_W_OFF,
        dm_r:   DM_R_OFF,
        alu_op: ALU_NOP,
        m2r:    1'b0,
        wsel:   GPR_XP
    };

endpackage

// File: rtl/pipe_skid_buf.sv
// Single overflow entry for pipe_stage_reg: catches the beat accepted while the main register
// is stalled. Only instantiated when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush, stall counter and optional skid entry.
// Define PIPE_STAGE_SKID_EN for the 2-entry elastic variant with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = PIPE_DATA_W,
    parameter int                CTRL_W      = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEFAULT),
    parameter int                CNT_W       = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              in_fire;
    logic              main_free;
    logic              stalled;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic [CTRL_W-1:0] src_ctrl;

    assign main_free = !valid_q || out_ready;
    assign stalled   = valid_q && !out_ready;
    assign in_fire   = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (in_fire && !main_free),
        .pop     (main_free && skid_valid),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .valid   (skid_valid),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
    );

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready  = !skid_valid;
    // The skid entry is older than any incoming beat, so it refills main first.
    assign src_valid = skid_valid || in_fire;
    assign src_data  = skid_valid ? skid_data : in_data;
    assign src_ctrl  = skid_valid ? skid_ctrl : in_ctrl;
`else
    assign in_ready  = out_ready || !valid_q;
    assign src_valid = in_fire;
    assign src_data  = in_data;
    assign src_ctrl  = in_ctrl;
`endif

    // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;

        if (stalled && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
        end else if (main_free) begin
            if (src_valid) begin
                valid_d = 1'b1;
                data_d  = src_data;
                ctrl_d  = src_ctrl;
            end else begin
                // Payload is left untouched so an idle stage does not toggle its data bus.
                valid_d = 1'b0;
                ctrl_d  = CTRL_BUBBLE;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the payload flops are reset as well, so out_data reads 0 rather than X after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= CTRL_BUBBLE;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ctrl  = ctrl_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based occupancy model compared every cycle,
// directed scenarios with literal expectations, then randomized valid/ready/flush traffic.
module tb_pipe_stage_reg;

    localparam int          DW  = 64;
    localparam int          CW  = 16;
    localparam logic [15:0] BUB = 16'h0A50;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int MAX_OCC = SKID ? 2 : 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [15:0]   stall_cnt;

    logic          s_in_ready;
    logic          s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [CW-1:0] s_out_ctrl;
    logic [3:0]    s_stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy sharing the same inputs, used for saturation.
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .CNT_W(4)) u_sat (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .stall_cnt(s_stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the stage is a FIFO of at most MAX_OCC beats; the head is what is shown.
    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } beat_t;

    beat_t       mq[$];
    int unsigned m_cnt;
    logic [DW-1:0] m_last;
    bit          m_in_fire;
    bit          chk_en = 1'b0;
    int          m_occ;
    bit          m_inf;
    bit          m_of;

    function automatic bit exp_in_ready(input int occ, input logic ordy);
        return (occ < MAX_OCC) || (!SKID && occ == MAX_OCC && ordy);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_cnt     = 0;
            m_last    = '0;
            m_in_fire = 1'b0;
        end else begin
            m_occ = mq.size();
            m_inf = in_valid && exp_in_ready(m_occ, out_ready);
            m_of  = (m_occ > 0) && out_ready;
            if (m_occ > 0 && !out_ready) m_cnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_of) void'(mq.pop_front());
                if (m_inf) mq.push_back('{data: in_data, ctrl: in_ctrl});
            end
            if (mq.size() > 0) m_last = mq[0].data;
            m_in_fire = m_inf;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("out_ctrl", 64'(out_ctrl), 64'((mq.size() > 0) ? mq[0].ctrl : BUB));
            check("out_data", out_data, m_last);
            check("in_ready", 64'(in_ready), 64'(exp_in_ready(mq.size(), out_ready)));
            check("stall_cnt", 64'(stall_cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
            check("stall_cnt_sat", 64'(s_stall_cnt), 64'((m_cnt > 15) ? 15 : m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle with inputs as they are, checks the reset state, then idles.
    task automatic reset_dut();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'(BUB));
        check("rst_out_data", out_data, 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int unsigned seq;
        reset_n   = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #10;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        reset_dut();

        // Streaming at full throughput.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = DW'(i);
            in_ctrl = 16'h1000 + 16'(i);
            tick();
            check("stream_data", out_data, 64'(i));
            check("stream_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", 64'(out_valid), 64'd0);
        check("stream_drain_ctrl", 64'(out_ctrl), 64'(BUB));
        check("stream_stall_cnt", 64'(stall_cnt), 64'd0);

        // Stall with a second beat pending behind it.
        reset_dut();
        in_valid  = 1'b1;
        in_data   = 64'hA5;
        in_ctrl   = 16'h1111;
        out_ready = 1'b0;
        tick();
        in_data = 64'hB6;
        in_ctrl = 16'h2222;
        repeat (5) begin
            tick();
            if (m_in_fire) in_valid = 1'b0;
        end
        check("stall_data", out_data, 64'hA5);
        check("stall_ctrl", 64'(out_ctrl), 64'h1111);
        check("stall_cnt5", 64'(stall_cnt), 64'd5);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        if (m_in_fire) in_valid = 1'b0;
        check("release_data", out_data, 64'hB6);
        check("release_ctrl", 64'(out_ctrl), 64'h2222);
        tick();
        check("release_drain", 64'(out_valid), 64'd0);
        check("release_hold_data", out_data, 64'hB6);

        // Flush while stalled, then flush while a beat is accepted.
        for (int pass = 0; pass < 2; pass++) begin
            reset_dut();
            in_valid  = 1'b1;
            in_data   = 64'h11;
            in_ctrl   = 16'h3333;
            out_ready = 1'b0;
            tick();
            in_data   = 64'hC7;
            in_ctrl   = 16'h4444;
            out_ready = (pass == 1);
            flush     = 1'b1;
            tick();
            flush    = 1'b0;
            in_valid = 1'b0;
            check("flush_valid", 64'(out_valid), 64'd0);
            check("flush_ctrl", 64'(out_ctrl), 64'(BUB));
            check("flush_data_held", out_data, 64'h11);
            check("flush_in_ready", 64'(in_ready), 64'd1);
            out_ready = 1'b1;
            repeat (2) tick();
            check("flush_no_c7", 64'(out_valid), 64'd0);
        end

        // Counter saturation, then reset mid-stall and mid-flush.
        reset_dut();
        in_valid  = 1'b1;
        in_data   = 64'h5A;
        in_ctrl   = 16'h5555;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("sat_main_cnt", 64'(stall_cnt), 64'd20);
        check("sat_small_cnt", 64'(s_stall_cnt), 64'd15);
        tick();
        check("sat_small_hold", 64'(s_stall_cnt), 64'd15);
        flush = 1'b1;
        reset_dut();

        // Randomized traffic; beats carry a sequence number so loss/dup/reorder shows in out_data.
        seq = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) reset_dut();
            if (m_in_fire || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = {32'(seq), $urandom()};
                in_ctrl  = 16'($urandom());
                seq++;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
